// File: rtl/bank_req_router.sv
// bank_req_router: request front-end for a multi-sub-bank memory bank.
// Registered per-sub-bank issue, fixed-latency read capture, credit-guarded response FIFO.
module bank_req_router #(
  parameter  int SUBBANKS_PER_BANK = 8,
  parameter  int LINE_WIDTH        = 400,
  parameter  int DEPTH_PER_SUBBANK = 1024,
  parameter  int RD_LAT            = 2,
  parameter  int FIFO_DEPTH        = 8,
  localparam int SBW = $clog2(SUBBANKS_PER_BANK),
  localparam int AAW = $clog2(DEPTH_PER_SUBBANK),
  localparam int CW  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_we,
  input  logic [SBW+AAW-1:0]                    req_addr,
  input  logic [LINE_WIDTH-1:0]                 req_wdata,
  output logic [SUBBANKS_PER_BANK-1:0]          we_bus,
  output logic [SUBBANKS_PER_BANK*AAW-1:0]      waddr_bus,
  output logic [SUBBANKS_PER_BANK*LINE_WIDTH-1:0] wdata_bus,
  output logic [SUBBANKS_PER_BANK-1:0]          re_bus,
  output logic [SUBBANKS_PER_BANK*AAW-1:0]      raddr_bus,
  input  logic [SUBBANKS_PER_BANK*LINE_WIDTH-1:0] rdata_bus,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [LINE_WIDTH-1:0]                 rsp_data,
  output logic [CW-1:0]                         rd_outstanding
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NS = SUBBANKS_PER_BANK;

  logic          acc;
  logic          rd_acc;
  logic          pop;
  logic          push;
  logic [SBW-1:0] sb;
  logic [AAW-1:0] row;

  logic [CW-1:0] credits_q, credits_d;

  logic [NS-1:0]            we_q, we_d;
  logic [NS-1:0]            re_q, re_d;
  logic [NS*AAW-1:0]        waddr_q, waddr_d;
  logic [NS*AAW-1:0]        raddr_q, raddr_d;
  logic [NS*LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                     iss_rd_q;
  logic [SBW-1:0]           iss_idx_q;

  logic [RD_LAT-1:0] pv_q;
  logic [SBW-1:0]    pidx_q [RD_LAT];

  logic [LINE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [LINE_WIDTH-1:0] push_data;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  assign sb  = req_addr[SBW-1:0];
  assign row = req_addr[SBW +: AAW];

  assign req_ready = (credits_q != '0);
  assign acc       = req_valid && req_ready;
  assign rd_acc    = acc && !req_we;
  assign pop       = rsp_valid && rsp_ready;

  // Credits cover both in-flight reads and queued responses.
  assign credits_d = credits_q - CW'(rd_acc) + CW'(pop);

  always_comb begin
    we_d    = '0;
    re_d    = '0;
    waddr_d = '0;
    raddr_d = '0;
    wdata_d = '0;
    if (acc) begin
      if (req_we) begin
        we_d[sb]                          = 1'b1;
        waddr_d[sb*AAW +: AAW]            = row;
        wdata_d[sb*LINE_WIDTH +: LINE_WIDTH] = req_wdata;
      end else begin
        re_d[sb]               = 1'b1;
        raddr_d[sb*AAW +: AAW] = row;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= CW'(FIFO_DEPTH);
      we_q      <= '0;
      re_q      <= '0;
      waddr_q   <= '0;
      raddr_q   <= '0;
      wdata_q   <= '0;
      iss_rd_q  <= 1'b0;
      iss_idx_q <= '0;
    end else begin
      credits_q <= credits_d;
      we_q      <= we_d;
      re_q      <= re_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      wdata_q   <= wdata_d;
      iss_rd_q  <= rd_acc;
      iss_idx_q <= sb;
    end
  end

  // Tag pipeline tracks which slice of rdata_bus holds each read's line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pidx_q[i] <= '0;
    end else begin
      pv_q[0]   <= iss_rd_q;
      pidx_q[0] <= iss_idx_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        pidx_q[i] <= pidx_q[i-1];
      end
    end
  end

  assign push      = pv_q[RD_LAT-1];
  assign push_data = rdata_bus[pidx_q[RD_LAT-1]*LINE_WIDTH +: LINE_WIDTH];

  assign wptr_d = wptr_q + PW'(push);
  assign rptr_d = rptr_q + PW'(pop);
  assign cnt_d  = cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  assign rsp_valid      = (cnt_q != '0);
  assign rsp_data       = rsp_valid ? mem_q[rptr_q] : '0;
  assign rd_outstanding = CW'(FIFO_DEPTH) - credits_q;

  assign we_bus    = we_q;
  assign re_bus    = re_q;
  assign waddr_bus = waddr_q;
  assign raddr_bus = raddr_q;
  assign wdata_bus = wdata_q;

endmodule

// File: tb/tb_bank_req_router.sv
// tb_bank_req_router: randomized scenarios against a queue-based reference model.
// A behavioural bank answers the bus; expected lines come from a model memory.
module tb_bank_req_router;

  localparam int NS  = 8;
  localparam int LW  = 400;
  localparam int AAW = 10;
  localparam int AW  = 13;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AW-1:0]     req_addr;
  logic [LW-1:0]     req_wdata;
  logic [NS-1:0]     we_bus;
  logic [NS*AAW-1:0] waddr_bus;
  logic [NS*LW-1:0]  wdata_bus;
  logic [NS-1:0]     re_bus;
  logic [NS*AAW-1:0] raddr_bus;
  logic [NS*LW-1:0]  rdata_bus;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [LW-1:0]     rsp_data;
  logic [3:0]        rd_outstanding;

  bank_req_router dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .we_bus(we_bus), .waddr_bus(waddr_bus), .wdata_bus(wdata_bus),
    .re_bus(re_bus), .raddr_bus(raddr_bus), .rdata_bus(rdata_bus),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rd_outstanding(rd_outstanding)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [LW-1:0] ref_mem [int];
  logic [LW-1:0] bmem [int];
  logic [LW-1:0] exp_q [$];
  int            out_cnt = 0;

  bit            acc, pop;
  logic [LW-1:0] got, exp;

  function automatic logic [LW-1:0] init_line(input int a);
    logic [415:0] t;
    for (int i = 0; i < 13; i++)
      t[i*32 +: 32] = ((a + 1) * 32'h9E3779B1) ^ (i * 32'h01000193);
    return t[LW-1:0];
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [415:0] t;
    for (int i = 0; i < 13; i++) t[i*32 +: 32] = $urandom;
    return t[LW-1:0];
  endfunction

  function automatic logic [LW-1:0] ref_at(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_line(a);
  endfunction

  function automatic logic [LW-1:0] bank_at(input int a);
    if (bmem.exists(a)) return bmem[a];
    return init_line(a);
  endfunction

  // Behavioural bank: writes land at the edge, reads return RD_LAT=2 edges later.
  logic [NS*LW-1:0] bpipe0, bpipe1;
  always @(posedge clk) begin : bank
    logic [NS*LW-1:0] nv;
    for (int s = 0; s < NS; s++)
      if (we_bus[s])
        bmem[int'(waddr_bus[s*AAW +: AAW]) * NS + s] = wdata_bus[s*LW +: LW];
    for (int s = 0; s < NS; s++) begin
      if (re_bus[s])
        nv[s*LW +: LW] = bank_at(int'(raddr_bus[s*AAW +: AAW]) * NS + s);
      else
        nv[s*LW +: LW] = rnd_line();
    end
    bpipe0 <= nv;
    bpipe1 <= bpipe0;
  end
  assign rdata_bus = bpipe1;

  // One cycle: drive at negedge, note handshakes, update the model, return at next negedge.
  task automatic tick(input bit v, input bit we, input logic [AW-1:0] a,
                      input logic [LW-1:0] wd, input bit rr,
                      output bit acc_o, output bit pop_o,
                      output logic [LW-1:0] got_o, output logic [LW-1:0] exp_o);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    rsp_ready = rr;
    #1;
    acc_o = v && req_ready;
    pop_o = rsp_valid && rr;
    got_o = rsp_data;
    exp_o = 'x;
    if (pop_o) begin
      if (exp_q.size() > 0) exp_o = exp_q.pop_front();
      out_cnt--;
    end
    if (acc_o && we) ref_mem[int'(a)] = wd;
    if (acc_o && !we) begin
      exp_q.push_back(ref_at(int'(a)));
      out_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
    repeat (2) @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%0b exp=1", req_ready);
    end
    total++;
    if ({we_bus, re_bus, rsp_valid, rd_outstanding} !== 21'd0) begin
      bad++; $display("FAIL reset_ctrl we=%h re=%h v=%0b out=%0d exp=0",
                      we_bus, re_bus, rsp_valid, rd_outstanding);
    end
    total++;
    if ((|waddr_bus) || (|raddr_bus) || (|wdata_bus) || (|rsp_data) !== 1'b0) begin
      bad++; $display("FAIL reset_data nonzero bus or rsp_data, exp all 0");
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick(1, 0, AW'($urandom), '0, 0, acc, pop, got, exp);
    total++;
    if ({rsp_valid, rd_outstanding} !== 5'b1_0100) begin
      bad++; $display("FAIL burst_state v=%0b out=%0d exp v=1 out=4", rsp_valid, rd_outstanding);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({we_bus, re_bus, rsp_valid, rd_outstanding, req_ready} !== 22'd1) begin
      bad++; $display("FAIL async_reset we=%h re=%h v=%0b out=%0d rdy=%0b exp 0/0/0/0/1",
                      we_bus, re_bus, rsp_valid, rd_outstanding, req_ready);
    end
    @(negedge clk);
    req_valid = 0;
    rst = 1'b0;
    exp_q.delete();
    out_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, '0, '0, 1, acc, pop, got, exp);
      total++;
      if ({rsp_valid, rd_outstanding, req_ready} !== 6'b0_0000_1) begin
        bad++; $display("FAIL post_reset_%0d v=%0b out=%0d rdy=%0b exp 0/0/1",
                        i, rsp_valid, rd_outstanding, req_ready);
      end
    end
  endtask

  task automatic test_write_read();
    logic [LW-1:0] d;
    d = {50{8'hA5}};
    tick(1, 1, 13'h00B, d, 1, acc, pop, got, exp);
    total++;
    if (we_bus !== 8'h08 || re_bus !== 8'h00) begin
      bad++; $display("FAIL wr_enable we=%h re=%h exp we=08 re=00", we_bus, re_bus);
    end
    total++;
    if (waddr_bus[3*AAW +: AAW] !== 10'd1 || wdata_bus[3*LW +: LW] !== d) begin
      bad++; $display("FAIL wr_slice row=%0d exp row=1 data=%h", waddr_bus[3*AAW +: AAW],
                      wdata_bus[3*LW +: LW]);
    end
    tick(1, 0, 13'h00B, '0, 1, acc, pop, got, exp);
    total++;
    if (we_bus !== 8'h00 || re_bus !== 8'h08 || raddr_bus[3*AAW +: AAW] !== 10'd1) begin
      bad++; $display("FAIL rd_issue we=%h re=%h row=%0d exp we=00 re=08 row=1",
                      we_bus, re_bus, raddr_bus[3*AAW +: AAW]);
    end
    tick(0, 0, '0, '0, 1, acc, pop, got, exp);
    tick(0, 0, '0, '0, 1, acc, pop, got, exp);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rd_early got rsp_valid=%0b exp 0", rsp_valid);
    end
    tick(0, 0, '0, '0, 1, acc, pop, got, exp);
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== d) begin
      bad++; $display("FAIL rd_latency v=%0b data=%h exp v=1 data=a5..", rsp_valid, rsp_data);
    end
    tick(0, 0, '0, '0, 1, acc, pop, got, exp);
    total++;
    if (!pop || got !== exp || rd_outstanding !== 4'd0) begin
      bad++; $display("FAIL rd_pop pop=%0b got=%h exp=%h out=%0d", pop, got, exp, rd_outstanding);
    end
  endtask

  task automatic test_sweep();
    int first, last, n;
    first = -1; last = -1; n = 0;
    for (int k = 0; k < 16; k++) begin
      tick(k < 8, 0, AW'(k), '0, 1, acc, pop, got, exp);
      if (k < 8) begin
        total++;
        if (re_bus !== 8'(1 << k)) begin
          bad++; $display("FAIL sweep_re_%0d got=%h exp=%h", k, re_bus, 8'(1 << k));
        end
      end
      if (pop) begin
        total++;
        if (got !== exp) begin
          bad++; $display("FAIL sweep_data_%0d got=%h exp=%h", n, got, exp);
        end
        if (first < 0) first = k;
        last = k;
        n++;
      end
    end
    total++;
    if (n != 8 || first != 4 || last != 11) begin
      bad++; $display("FAIL sweep_b2b pops=%0d first=%0d last=%0d exp 8/4/11", n, first, last);
    end
  endtask

  task automatic test_credit();
    int nacc;
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, AW'($urandom), '0, 0, acc, pop, got, exp);
      nacc += int'(acc);
    end
    total++;
    if (nacc != 8 || req_ready !== 1'b0 || rd_outstanding !== 4'd8) begin
      bad++; $display("FAIL credit_fill acc=%0d rdy=%0b out=%0d exp 8/0/8",
                      nacc, req_ready, rd_outstanding);
    end
    for (int i = 0; i < 4; i++) tick(1, 0, AW'($urandom), '0, 0, acc, pop, got, exp);
    tick(1, 0, AW'($urandom), '0, 1, acc, pop, got, exp);
    total++;
    if (!pop || acc || got !== exp) begin
      bad++; $display("FAIL credit_pop pop=%0b acc=%0b got=%h exp=%h", pop, acc, got, exp);
    end
    total++;
    if (req_ready !== 1'b1 || rd_outstanding !== 4'd7) begin
      bad++; $display("FAIL credit_free rdy=%0b out=%0d exp 1/7", req_ready, rd_outstanding);
    end
    nacc = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, AW'($urandom), '0, 0, acc, pop, got, exp);
      nacc += int'(acc);
    end
    total++;
    if (nacc != 1 || rd_outstanding !== 4'd8) begin
      bad++; $display("FAIL credit_one acc=%0d out=%0d exp 1/8", nacc, rd_outstanding);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (exp_q.size() > 0 || rsp_valid); i++) begin
      tick(0, 0, '0, '0, 1, acc, pop, got, exp);
      if (pop) begin
        total++;
        if (got !== exp) begin
          bad++; $display("FAIL %s_drain got=%h exp=%h", tag, got, exp);
        end
      end
    end
    total++;
    if (exp_q.size() != 0 || rd_outstanding !== 4'd0) begin
      bad++; $display("FAIL %s_empty left=%0d out=%0d exp 0/0", tag, exp_q.size(), rd_outstanding);
    end
  endtask

  task automatic test_full_stream();
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, AW'($urandom), '0, 1, acc, pop, got, exp);
      total++;
      if (!pop || got !== exp) begin
        bad++; $display("FAIL stream_%0d pop=%0b got=%h exp=%h", i, pop, got, exp);
      end
      total++;
      if (rd_outstanding !== 4'(out_cnt) || out_cnt < 7) begin
        bad++; $display("FAIL stream_cred_%0d out=%0d exp=%0d (7..8)", i, rd_outstanding, out_cnt);
      end
    end
    drain("stream");
  endtask

  task automatic test_idle_slices();
    logic [LW-1:0] d;
    logic [AAW-1:0] r;
    tick(0, 0, '0, '0, 1, acc, pop, got, exp);
    total++;
    if ((|we_bus) || (|re_bus) || (|waddr_bus) || (|raddr_bus) || (|wdata_bus)) begin
      bad++; $display("FAIL idle_bus we=%h re=%h exp all 0", we_bus, re_bus);
    end
    d = rnd_line();
    r = AAW'($urandom_range(1, 1023));
    tick(1, 1, {r, 3'd7}, d, 1, acc, pop, got, exp);
    total++;
    if (we_bus !== 8'h80 || re_bus !== 8'h00 || (|raddr_bus)) begin
      bad++; $display("FAIL sb7_enable we=%h re=%h exp 80/00", we_bus, re_bus);
    end
    total++;
    if (waddr_bus[7*AAW +: AAW] !== r || (|waddr_bus[7*AAW-1:0])) begin
      bad++; $display("FAIL sb7_waddr got=%h exp row=%0d only in slice 7", waddr_bus, r);
    end
    total++;
    if (wdata_bus[7*LW +: LW] !== d || (|wdata_bus[7*LW-1:0])) begin
      bad++; $display("FAIL sb7_wdata slice7=%h exp=%h others must be 0", wdata_bus[7*LW +: LW], d);
    end
  endtask

  task automatic test_random();
    bit v, we, rr;
    logic [AW-1:0] a;
    logic [NS-1:0] ewe, ere;
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom % 4) != 0;
      we = ($urandom % 3) == 0;
      rr = ($urandom % 3) != 0;
      a  = {AAW'($urandom_range(0, 3)), 3'($urandom)};
      tick(v, we, a, rnd_line(), rr, acc, pop, got, exp);
      ewe = (acc && we)  ? 8'(1 << a[2:0]) : 8'h00;
      ere = (acc && !we) ? 8'(1 << a[2:0]) : 8'h00;
      total++;
      if (we_bus !== ewe || re_bus !== ere) begin
        bad++; $display("FAIL rand_bus_%0d we=%h re=%h exp %h/%h", i, we_bus, re_bus, ewe, ere);
      end
      total++;
      if (rd_outstanding !== 4'(out_cnt) || req_ready !== (out_cnt < 8)) begin
        bad++; $display("FAIL rand_cred_%0d out=%0d rdy=%0b exp out=%0d", i, rd_outstanding,
                        req_ready, out_cnt);
      end
      if (pop) begin
        total++;
        if (got !== exp) begin
          bad++; $display("FAIL rand_data_%0d got=%h exp=%h", i, got, exp);
        end
      end
    end
    drain("rand");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_sweep();
    test_credit();
    test_full_stream();
    test_idle_slices();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
